// File: rtl/apb_gpio_pkg.sv
// Shared constants for the APB GPIO slave: bus widths, register offsets,
// wait-state counter width and the transfer FSM state encoding.
package apb_gpio_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WCNT_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DOUT  = 8'h00;
    localparam logic [ADDR_W-1:0] ADDR_DIR   = 8'h04;
    localparam logic [ADDR_W-1:0] ADDR_DIN   = 8'h08;
    localparam logic [ADDR_W-1:0] ADDR_IEN   = 8'h0C;
    localparam logic [ADDR_W-1:0] ADDR_ISTAT = 8'h10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/gpio_sync.sv
// Per-bit two-flop synchronizer for asynchronous GPIO pins, plus a
// rising-edge detector on the synchronized value.
// Config macro: GPIO_IRQ_EN (edge detector present only when defined;
// otherwise rise_c is tied low).
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   async_in    - raw pin inputs
//   sync_out    - synchronized pin values (two-cycle latency)
//   rise_c      - combinational one-cycle pulse on a synchronized 0->1
module gpio_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_c
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev_q;

    // Previous synchronized sample for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_q;
        end
    end

    assign rise_c = sync_q & ~prev_q;
`else
    assign rise_c = '0;
`endif

endmodule

// File: rtl/apb_gpio_slave.sv
// APB slave exposing a GPIO block: output data, direction, synchronized
// input, and (optionally) rising-edge interrupt enable/status registers.
// Config macro: GPIO_IRQ_EN (IEN/ISTAT registers and irq; when undefined
// those offsets decode as errors and irq is tied low).
// Ports:
//   PCLK, PRESETn                 - bus clock, async active-low reset
//   PSEL, PENABLE, PWRITE         - APB control
//   PADDR, PWDATA                 - byte offset, write data
//   PRDATA, PREADY, PSLVERR       - registered APB response
//   gpio_in                       - asynchronous pin inputs
//   gpio_out, gpio_oe             - pin output values / drive enables
//   irq                           - registered interrupt request
module apb_gpio_slave
    import apb_gpio_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic [GPIO_WIDTH-1:0] dout_q;
    logic [GPIO_WIDTH-1:0] dir_q;
    logic [GPIO_WIDTH-1:0] din;
    logic [GPIO_WIDTH-1:0] rise_c;
    logic [GPIO_WIDTH-1:0] wdata_c;

    logic [DATA_W-1:0]   prdata_q;
    logic                pready_q;
    logic                pslverr_q;

    logic                addr_ok_c;
    logic [DATA_W-1:0]   rd_data_c;
    logic                wr_commit_c;
    logic                to_access_c;

    logic                unused_wdata;

    assign wdata_c      = PWDATA[GPIO_WIDTH-1:0];
    assign unused_wdata = ^PWDATA;

    gpio_sync #(
        .WIDTH (GPIO_WIDTH)
    ) u_sync (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .async_in (gpio_in),
        .sync_out (din),
        .rise_c   (rise_c)
    );

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] ien_q;
    logic [GPIO_WIDTH-1:0] istat_q, istat_d;
    logic                  irq_q;
`endif

    // Address decode and read mux; unaligned offsets never match an entry
    always_comb begin
        addr_ok_c = 1'b0;
        rd_data_c = '0;
        case (PADDR)
            ADDR_DOUT: begin
                addr_ok_c = 1'b1;
                rd_data_c = DATA_W'(dout_q);
            end
            ADDR_DIR: begin
                addr_ok_c = 1'b1;
                rd_data_c = DATA_W'(dir_q);
            end
            ADDR_DIN: begin
                addr_ok_c = !PWRITE;
                rd_data_c = DATA_W'(din);
            end
`ifdef GPIO_IRQ_EN
            ADDR_IEN: begin
                addr_ok_c = 1'b1;
                rd_data_c = DATA_W'(ien_q);
            end
            ADDR_ISTAT: begin
                addr_ok_c = 1'b1;
                rd_data_c = DATA_W'(istat_q);
            end
`endif
            default: begin
                addr_ok_c = 1'b0;
                rd_data_c = '0;
            end
        endcase
    end

    // Transfer FSM next state; wait counter only advances in access phase
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                if (PSEL && !PENABLE) begin
                    state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else if (PENABLE) begin
                    if (wcnt_q == WCNT_W'(WAIT_STATES - 1)) begin
                        state_d = ACCESS;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            ACCESS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Response flops are loaded as the FSM enters ACCESS so they hold
    // for exactly the PREADY cycle and are zero otherwise
    assign to_access_c = (state_d == ACCESS);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= to_access_c;
            pslverr_q <= to_access_c && !addr_ok_c;
            prdata_q  <= (to_access_c && !PWRITE && addr_ok_c) ? rd_data_c : '0;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

    assign wr_commit_c = PSEL && PENABLE && pready_q && PWRITE && addr_ok_c;

    // Output data and direction registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            dout_q <= '0;
            dir_q  <= '0;
        end else if (wr_commit_c) begin
            if (PADDR == ADDR_DOUT) dout_q <= wdata_c;
            if (PADDR == ADDR_DIR)  dir_q  <= wdata_c;
        end
    end

    assign gpio_out = dout_q;
    assign gpio_oe  = dir_q;

`ifdef GPIO_IRQ_EN
    // W1C clear first, then new edges OR in so a same-cycle edge wins
    always_comb begin
        istat_d = istat_q;
        if (wr_commit_c && (PADDR == ADDR_ISTAT)) begin
            istat_d = istat_d & ~wdata_c;
        end
        istat_d = istat_d | (rise_c & ien_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ien_q   <= '0;
            istat_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_commit_c && (PADDR == ADDR_IEN)) ien_q <= wdata_c;
            istat_q <= istat_d;
            irq_q   <= |istat_q;
        end
    end

    assign irq = irq_q;
`else
    logic unused_rise;
    assign unused_rise = |rise_c;
    assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Scoreboard bench for apb_gpio_slave: the transfer task queues the
// expected response, a negedge monitor pops and compares on PREADY.
module tb_apb_gpio_slave;

    localparam int unsigned GW = 8;
    localparam int unsigned WS = 1;

    logic          PCLK;
    logic          PRESETn;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [7:0]    PADDR;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [GW-1:0] gpio_in;
    logic [GW-1:0] gpio_out;
    logic [GW-1:0] gpio_oe;
    logic          irq;

    apb_gpio_slave #(
        .GPIO_WIDTH  (GW),
        .WAIT_STATES (WS)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int passes = 0;
    int wait_cnt = 0;

    logic [31:0] q_rdata[$];
    logic        q_err[$];
    string       q_name[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Monitor: counts wait cycles and compares each completed transfer
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            wait_cnt = 0;
        end else if (PSEL && PENABLE) begin
            if (!PREADY) begin
                wait_cnt++;
                check("idle_resp_zero", {PRDATA[30:0], PSLVERR}, 32'd0);
            end else if (q_name.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pready: got PREADY=1 expected no transfer pending");
            end else begin
                string       nm;
                logic [31:0] er;
                logic        ee;
                nm = q_name.pop_front();
                er = q_rdata.pop_front();
                ee = q_err.pop_front();
                check({nm, "_prdata"}, PRDATA, er);
                check({nm, "_pslverr"}, 32'(PSLVERR), 32'(ee));
                check({nm, "_waits"}, 32'(wait_cnt), 32'(WS));
                wait_cnt = 0;
            end
        end
    end

    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input string name);
        int n;
        q_rdata.push_back(exp_rdata);
        q_err.push_back(exp_err);
        q_name.push_back(name);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PREADY && n < 20);
        if (!PREADY) begin
            checks++;
            $display("FAIL %s_timeout: got no PREADY in %0d cycles expected PREADY", name, n);
            void'(q_name.pop_back());
            void'(q_rdata.pop_back());
            void'(q_err.pop_back());
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; gpio_in = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pready",   32'(PREADY),   32'd0);
        check("rst_pslverr",  32'(PSLVERR),  32'd0);
        check("rst_prdata",   PRDATA,        32'd0);
        check("rst_gpio_out", 32'(gpio_out), 32'd0);
        check("rst_gpio_oe",  32'(gpio_oe),  32'd0);
        check("rst_irq",      32'(irq),      32'd0);
        PRESETn = 1'b1;

        // Basic DOUT/DIR traffic
        apb(1'b1, 8'h00, 32'h0000_00A5, 32'd0, 1'b0, "wr_dout_a5");
        check("gpio_out_a5", 32'(gpio_out), 32'h0000_00A5);
        apb(1'b0, 8'h00, 32'd0, 32'h0000_00A5, 1'b0, "rd_dout_a5");
        apb(1'b1, 8'h04, 32'h0000_000F, 32'd0, 1'b0, "wr_dir_0f");
        apb(1'b0, 8'h04, 32'd0, 32'h0000_000F, 1'b0, "rd_dir_0f");
        check("gpio_oe_0f", 32'(gpio_oe), 32'h0000_000F);

        // DIN through the synchronizer; DIN is read-only
        gpio_in = 8'h3C;
        repeat (3) @(posedge PCLK);
        apb(1'b0, 8'h08, 32'd0, 32'h0000_003C, 1'b0, "rd_din_3c");
        apb(1'b1, 8'h08, 32'h0000_00FF, 32'd0, 1'b1, "wr_din_err");
        apb(1'b0, 8'h08, 32'd0, 32'h0000_003C, 1'b0, "rd_din_kept");

        // Unmapped and unaligned offsets
        apb(1'b1, 8'h20, 32'h0000_0055, 32'd0, 1'b1, "wr_unmapped");
        apb(1'b0, 8'h20, 32'd0, 32'd0, 1'b1, "rd_unmapped");
        apb(1'b1, 8'h02, 32'h0000_0055, 32'd0, 1'b1, "wr_unaligned");
        apb(1'b0, 8'h02, 32'd0, 32'd0, 1'b1, "rd_unaligned");
        apb(1'b0, 8'h00, 32'd0, 32'h0000_00A5, 1'b0, "rd_dout_after_err");
        apb(1'b0, 8'h04, 32'd0, 32'h0000_000F, 1'b0, "rd_dir_after_err");

        // Bits above GPIO_WIDTH are dropped and read back as zero
        apb(1'b1, 8'h00, 32'hFFFF_FF5A, 32'd0, 1'b0, "wr_dout_wide");
        apb(1'b0, 8'h00, 32'd0, 32'h0000_005A, 1'b0, "rd_dout_5a");

`ifdef GPIO_IRQ_EN
        apb(1'b1, 8'h0C, 32'h0000_0001, 32'd0, 1'b0, "wr_ien_01");
        apb(1'b0, 8'h0C, 32'd0, 32'h0000_0001, 1'b0, "rd_ien_01");
        gpio_in = 8'h3D;
        repeat (5) @(posedge PCLK);
        #1;
        check("irq_set", 32'(irq), 32'd1);
        apb(1'b0, 8'h10, 32'd0, 32'h0000_0001, 1'b0, "rd_istat_01");
        apb(1'b1, 8'h10, 32'h0000_0001, 32'd0, 1'b0, "wr_istat_clr");
        repeat (2) @(posedge PCLK);
        #1;
        check("irq_cleared", 32'(irq), 32'd0);
        apb(1'b0, 8'h10, 32'd0, 32'd0, 1'b0, "rd_istat_00");
`else
        apb(1'b1, 8'h0C, 32'h0000_0001, 32'd0, 1'b1, "wr_ien_unmapped");
        apb(1'b0, 8'h10, 32'd0, 32'd0, 1'b1, "rd_istat_unmapped");
        gpio_in = 8'h3D;
        repeat (5) @(posedge PCLK);
        #1;
        check("irq_tied_low", 32'(irq), 32'd0);
`endif

        // PSEL dropped during WAIT: no completion, no write
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h0000_0011;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PWRITE = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            check("psel_drop_pready", 32'(PREADY), 32'd0);
        end
        check("psel_drop_gpio_out", 32'(gpio_out), 32'h0000_005A);
        apb(1'b0, 8'h00, 32'd0, 32'h0000_005A, 1'b0, "rd_after_psel_drop");

        // Reset during WAIT of a write aborts it
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h0000_00FF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        PRESETn = 1'b0;
        #1;
        check("rst_mid_pready",   32'(PREADY),   32'd0);
        check("rst_mid_gpio_out", 32'(gpio_out), 32'd0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_release_gpio_out", 32'(gpio_out), 32'd0);
        check("rst_release_pready",   32'(PREADY),   32'd0);
        apb(1'b0, 8'h00, 32'd0, 32'd0, 1'b0, "rd_dout_after_rst");
        apb(1'b0, 8'h04, 32'd0, 32'd0, 1'b0, "rd_dir_after_rst");

        repeat (3) @(posedge PCLK);
        if (q_name.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_name.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
